// File: rtl/text_console_writer.sv
// Byte-stream writer for the 32x32 character RAM: prints at a hardware cursor,
// handles CR/LF/FF, and clears the screen after reset and each new line on entry.
module text_console_writer #(
  parameter logic [7:0] FILL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  output logic [4:0] cursor_row,
  output logic [4:0] cursor_col,
  output logic       busy
);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    S_CLEAR_ALL,
    S_IDLE,
    S_EXEC,
    S_CLEAR_ROW
  } state_e;

  state_e     state_q;
  logic [9:0] clr_cnt_q;
  logic [4:0] row_q;
  logic [4:0] col_q;
  logic [7:0] byte_q;

  logic [4:0] row_d;
  logic       printable;

  // 5-bit arithmetic gives the bottom-to-top wrap for free.
  assign row_d     = row_q + 5'd1;
  assign printable = !(byte_q inside {CH_CR, CH_LF, CH_FF});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_CLEAR_ALL;
      clr_cnt_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      byte_q    <= '0;
    end else begin
      case (state_q)
        S_CLEAR_ALL: begin
          clr_cnt_q <= clr_cnt_q + 10'd1;
          if (clr_cnt_q == 10'd1023) state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (in_valid) begin
            byte_q  <= in_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          clr_cnt_q <= '0;
          case (byte_q)
            CH_CR: begin
              col_q   <= '0;
              state_q <= S_IDLE;
            end
            CH_LF: begin
              col_q   <= '0;
              row_q   <= row_d;
              state_q <= S_CLEAR_ROW;
            end
            CH_FF: begin
              col_q   <= '0;
              row_q   <= '0;
              state_q <= S_CLEAR_ALL;
            end
            default: begin
              if (col_q == 5'd31) begin
                col_q   <= '0;
                row_q   <= row_d;
                state_q <= S_CLEAR_ROW;
              end else begin
                col_q   <= col_q + 5'd1;
                state_q <= S_IDLE;
              end
            end
          endcase
        end
        S_CLEAR_ROW: begin
          clr_cnt_q <= clr_cnt_q + 10'd1;
          if (clr_cnt_q[4:0] == 5'd31) state_q <= S_IDLE;
        end
        default: state_q <= S_CLEAR_ALL;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = {row_q, col_q};
    ram_din  = FILL;
    case (state_q)
      S_CLEAR_ALL: begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt_q;
      end
      S_CLEAR_ROW: begin
        ram_we   = 1'b1;
        ram_addr = {row_q, clr_cnt_q[4:0]};
      end
      S_EXEC: begin
        ram_we  = printable;
        ram_din = byte_q;
      end
      default: ram_we = 1'b0;
    endcase
    // Reset kills the strobe in the same cycle, before the state register reacts.
    if (reset) ram_we = 1'b0;
  end

  assign in_ready   = !reset && (state_q == S_IDLE);
  assign busy       = reset || (state_q != S_IDLE);
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: table vectors, hand-written
// corner sequences and a random byte stream against a screen-level model.
module tb_text_console_writer;

  localparam logic [7:0] FILL  = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [4:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;

  text_console_writer #(.FILL(FILL)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] scr[1024];
  int         cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (ram_we) begin
      wq.push_back('{ram_addr, ram_din, cyc});
      scr[ram_addr] = ram_din;
    end
  end

  // Screen-level reference model.
  logic [7:0] ref_scr[1024];
  int         mr, mc;

  task automatic model_clear_row(input int r);
    for (int k = 0; k < 32; k++) ref_scr[r*32 + k] = FILL;
  endtask

  task automatic model_reset();
    for (int a = 0; a < 1024; a++) ref_scr[a] = FILL;
    mr = 0;
    mc = 0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    if (b == CH_CR) begin
      mc = 0;
    end else if (b == CH_LF) begin
      mc = 0;
      mr = (mr + 1) % 32;
      model_clear_row(mr);
    end else if (b == CH_FF) begin
      model_reset();
    end else begin
      ref_scr[mr*32 + mc] = b;
      mc = mc + 1;
      if (mc == 32) begin
        mc = 0;
        mr = (mr + 1) % 32;
        model_clear_row(mr);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cursor(input string name, input int r, input int c);
    check({name, "_row"}, 32'(cursor_row), r);
    check({name, "_col"}, 32'(cursor_col), c);
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting, expected completion", name);
  endtask

  task automatic wait_ready(output bit ok);
    int budget = 3000;
    ok = 1'b1;
    while (!in_ready) begin
      @(negedge clk);
      budget--;
      if (budget == 0) begin
        timeout("wait_ready");
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Waits for in_ready, transfers one byte, returns the cycles spent not ready.
  task automatic send(input logic [7:0] b, output int busy_cyc);
    bit ok;
    busy_cyc = 0;
    @(negedge clk);
    wait_ready(ok);
    if (!ok) return;
    wq.delete();
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      busy_cyc++;
      if (busy_cyc > 3000) begin
        timeout("send_busy");
        return;
      end
    end
  endtask

  task automatic check_clear_order(input string name, input int base, input int n);
    int bad = -1;
    check({name, "_count"}, wq.size(), n);
    foreach (wq[i])
      if (bad < 0 && (wq[i].addr !== 10'(base + i) || wq[i].data !== FILL)) bad = i;
    check({name, "_first_bad"}, bad, -1);
  endtask

  task automatic reset_and_check(input int hold);
    int lat = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      check("rst_we", ram_we, 1'b0);
      check("rst_ready", in_ready, 1'b0);
      check("rst_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    wq.delete();
    forever begin
      @(negedge clk);
      if (in_ready) break;
      lat++;
      if (lat > 3000) begin
        timeout("reset_clear");
        return;
      end
    end
    check("rst_ready_latency", lat, 1024);
    check_clear_order("rst_clear", 0, 1024);
    check_cursor("rst_cursor", 0, 0);
  endtask

  typedef struct {
    logic [7:0] b;
    int         row;
    int         col;
    int         nwr;
    int         nbusy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bc;
    bit  ok;
    int  ff_cnt;
    int  diffs;
    int  exp_busy;
    logic [7:0] b;

    // Sequence starts at cursor (0,2) after the held-valid print test.
    tbl[0] = '{CH_CR, 0, 0,    0,    1};
    tbl[1] = '{8'h31, 0, 1,    1,    1};
    tbl[2] = '{CH_LF, 1, 0,   32,   33};
    tbl[3] = '{8'h41, 1, 1,    1,    1};
    tbl[4] = '{CH_CR, 1, 0,    0,    1};
    tbl[5] = '{CH_FF, 0, 0, 1024, 1025};
    tbl[6] = '{8'h7E, 0, 1,    1,    1};

    reset_and_check(3);

    // Two bytes back to back with in_valid held high.
    @(negedge clk);
    wait_ready(ok);
    wq.delete();
    in_data  = 8'h31;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h32;
    @(negedge clk);
    check("print_exec1_ready", in_ready, 1'b0);
    @(negedge clk);
    check("print_idle_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("print_exec2_ready", in_ready, 1'b0);
    @(negedge clk);
    check("print_nwr", wq.size(), 2);
    if (wq.size() == 2) begin
      check("print_w0", {wq[0].addr, wq[0].data}, {10'd0, 8'h31});
      check("print_w1", {wq[1].addr, wq[1].data}, {10'd1, 8'h32});
      check("print_spacing", wq[1].cyc - wq[0].cyc, 2);
    end
    check_cursor("print_cursor", 0, 2);

    foreach (tbl[i]) begin
      send(tbl[i].b, bc);
      check($sformatf("tbl%0d_row", i), 32'(cursor_row), tbl[i].row);
      check($sformatf("tbl%0d_col", i), 32'(cursor_col), tbl[i].col);
      check($sformatf("tbl%0d_nwr", i), wq.size(), tbl[i].nwr);
      check($sformatf("tbl%0d_busy", i), bc, tbl[i].nbusy);
    end

    // Line wrap from column 31.
    repeat (30) send(8'h61, bc);
    check_cursor("wrap_pre", 0, 31);
    send(8'h35, bc);
    check("wrap_busy", bc, 33);
    check("wrap_nwr", wq.size(), 33);
    if (wq.size() > 0) begin
      check("wrap_data_wr", {wq[0].addr, wq[0].data}, {10'd31, 8'h35});
      void'(wq.pop_front());
      check_clear_order("wrap_row_clear", 32, 32);
    end
    check_cursor("wrap_cursor", 1, 0);

    // Bottom-row LF wraps to the top and clears row 0.
    repeat (30) send(CH_LF, bc);
    repeat (5) send(8'h62, bc);
    check_cursor("bottom_pre", 31, 5);
    send(CH_LF, bc);
    check_clear_order("bottom_clear", 0, 32);
    check_cursor("bottom_cursor", 0, 0);

    // CR then FF.
    repeat (4) send(CH_LF, bc);
    repeat (9) send(8'h63, bc);
    check_cursor("cr_pre", 4, 9);
    send(CH_CR, bc);
    check_cursor("cr_cursor", 4, 0);
    check("cr_nwr", wq.size(), 0);
    check("cr_busy", bc, 1);
    send(CH_FF, bc);
    check("ff_busy", bc, 1025);
    check_clear_order("ff_clear", 0, 1024);
    check_cursor("ff_cursor", 0, 0);

    // Reset during CLEAR_ROW at k=10.
    @(negedge clk);
    wait_ready(ok);
    in_data  = CH_LF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ram_we && ram_addr == {5'd1, 5'd10}) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("midreset_find_k10");
    reset = 1'b1;
    #1;
    check("midreset_we_drop", ram_we, 1'b0);
    check("midreset_ready", in_ready, 1'b0);
    reset_and_check(2);

    // Random stream against the screen model.
    model_reset();
    ff_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 8)                       b = CH_LF;
      else if (r < 12)                 b = CH_CR;
      else if (r == 12 && ff_cnt < 2)  begin b = CH_FF; ff_cnt++; end
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == CH_FF) b = 8'h46;
      end
      if (b == CH_CR)      exp_busy = 1;
      else if (b == CH_LF) exp_busy = 33;
      else if (b == CH_FF) exp_busy = 1025;
      else                 exp_busy = (mc == 31) ? 33 : 1;
      send(b, bc);
      model_apply(b);
      check($sformatf("rnd%0d_busy", n), bc, exp_busy);
      check($sformatf("rnd%0d_cursor", n), {27'd0, cursor_row, cursor_col}, 32'(mr*32 + mc));
    end
    diffs = 0;
    for (int a = 0; a < 1024; a++) if (scr[a] !== ref_scr[a]) diffs++;
    check("rnd_screen_diffs", diffs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
# text_console_writer

Upstream feeder for the 32x32 character RAM scanned by the text display. Accepts a byte stream over a valid/ready handshake, writes printable bytes into the RAM at a hardware cursor, and interprets a small set of control codes (line feed, carriage return, form feed). Drives the RAM write port (address, data, write enable), while the display keeps the read path. Clears the whole screen after reset and clears each new line as the cursor enters it.

## Interface
- `FILL`, default 8'h00: byte written to cleared cells.
- `clk`  input  1  system clock; same domain as the display and RAM.
- `reset`  input  1  synchronous, active-high reset.
- `in_data`  input  8  byte to print or control code.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a byte this cycle.
- `ram_addr`  output  10  `{row[4:0], col[4:0]}` write address.
- `ram_din`  output  8  write data.
- `ram_we`  output  1  write strobe; RAM samples on the `clk` edge.
- `cursor_row`  output  5  current cursor row.
- `cursor_col`  output  5  current cursor column.
- `busy`  output  1  high whenever the block is not in IDLE.

## Operation
- States:
  - CLEAR_ALL: writes `FILL` to `ram_addr` = clr_cnt, one cell per cycle. clr_cnt runs 0..1023, then goes to IDLE.
  - IDLE: `in_ready`=1. A transfer occurs when `in_valid && in_ready` at a clock edge; this captures the byte and goes to EXEC.
  - EXEC: one cycle that acts on the captured byte (below).
  - CLEAR_ROW: writes `FILL` to `{cursor_row, k}` for k = 0..31, then goes to IDLE.
- `in_ready` is 1 only in IDLE; `busy` = !IDLE.
- EXEC behaviour by captured byte:
  - 0x0D (CR): no write; col←0; next state IDLE.
  - 0x0A (LF): no write; col←0, row←row+1 (31 wraps to 0); next state CLEAR_ROW.
  - 0x0C (FF): no write; row←0, col←0, clr_cnt←0; next state CLEAR_ALL.
  - Any other value: `ram_we`=1, `ram_addr`={row,col}, `ram_din`=byte.
    - If col<31: col←col+1; next state IDLE.
    - If col==31: col←0, row←row+1 (wrapping); next state CLEAR_ROW.
- Cursor registers update at the end of EXEC. The write uses the pre-update cursor.
- Row arithmetic is 5-bit modulo 32. There is no scrolling: the bottom line wraps to the top, and the new top line is cleared.
- `ram_we` is 0 in IDLE and in non-printable EXEC. `ram_din` is don't-care when `ram_we`=0.
- Reset has priority over everything:
  - Next state is CLEAR_ALL with clr_cnt=0 and the cursor at (0,0).
  - While `reset`=1, `ram_we`=0, `in_ready`=0 and `busy`=1; `ram_we` is gated combinationally by `reset`.
  - Reset asserted in the middle of any state abandons that state. The in-flight byte is dropped and no partial cursor update occurs.

## Timing
- Outputs are combinational from registered state, counters and the captured byte. There are no extra output registers.
- Reset released before edge E0: the cycle after E0 writes addr 0. Addresses 0..1023 are written on consecutive cycles. `in_ready`=1 in the 1025th cycle after release (1024 clear cycles, then IDLE).
- Printable byte accepted at edge N (col<31): `ram_we`=1 in cycle N→N+1. The cursor advances at edge N+1. `in_ready`=1 again in cycle N+1→N+2. Sustained throughput is 1 byte per 2 cycles.
- Line change (LF, or printable at col 31):
  - EXEC takes 1 cycle, then CLEAR_ROW takes 32 cycles.
  - `in_ready` returns 33 cycles after the EXEC cycle begins.
- FF: EXEC takes 1 cycle, then 1024 clear cycles.
- `in_valid` may be held high while `in_ready`=0. Nothing is consumed until `in_ready`=1, and the data must stay stable until accepted.

## Test plan
- Reset clear: assert `reset` for 3 cycles, then release.
  - Required: exactly 1024 `ram_we` pulses, addresses 0..1023 in order, data `FILL`.
  - Required: `in_ready` first high 1024 cycles after release; cursor = (0,0).
- Print: send 0x31, 0x32 back-to-back with `in_valid` held high.
  - Required: writes (addr 0, 0x31) and (addr 1, 0x32), 2 cycles apart.
  - Required: cursor ends at (0,2); `in_ready` low during each EXEC cycle.
- Line wrap: place the cursor at (0,31) and send 0x35.
  - Required: write at addr 31.
  - Required: then 32 `FILL` writes at addr 32..63; cursor (1,0); `in_ready` returns 33 cycles after EXEC.
- Bottom wrap: cursor at (31,5), send LF.
  - Required: no data write; `FILL` written to addr 0..31; cursor (0,0).
- CR and FF:
  - At (4,9), send CR: cursor (4,0), no writes, `in_ready` back after 1 cycle.
  - Then send FF: 1024 clear writes; cursor (0,0).
- Reset mid-operation: assert `reset` during CLEAR_ROW at k=10.
  - Required: `ram_we` drops the same cycle.
  - Required: after release, a full CLEAR_ALL from addr 0; cursor (0,0).
